instr_register_pipe: RTL and testbench

Parametrised, pipelined successor of the instruction register. It accepts opcode/operand requests through a valid/ready handshake and computes results in a one-cycle ALU stage, or in an iterative divider for DIV/MOD. Each result is stored with status flags in a DEPTH-entry register file, and the file is read back through a registered read port. It sits between the instruction stimulus driver and the result checker, and exposes stall behaviour that the earlier block lacked.

---
 rtl/instr_register_pkg.sv | 25 ++
 rtl/instr_divider_serial.sv | 69 ++++++
 rtl/instr_register_pipe.sv | 184 ++++++++++++++++++
 tb/tb_instr_register_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register:
// opcode encoding, flag bit positions and an opcode helper.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   localparam int FLAG_DIV0    = 0;
   localparam int FLAG_CARRY   = 1;
   localparam int FLAG_ILLEGAL = 2;
   localparam int FLAG_WRITTEN = 3;

   function automatic logic is_div_op(input opcode_t op);
      return (op == DIV) || (op == MOD);
   endfunction

endpackage

// File: rtl/instr_divider_serial.sv
// Restoring divider: one quotient bit per cycle, OP_W iterations,
// done pulses for one cycle after the last iteration.
module instr_divider_serial #(
   parameter int OP_W = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [OP_W-1:0] dividend,
   input  logic [OP_W-1:0] divisor,
   output logic            done,
   output logic [OP_W-1:0] quotient,
   output logic [OP_W-1:0] remainder
);

   localparam int CW = $clog2(OP_W);

   logic [OP_W:0]   rem_q;
   logic [OP_W-1:0] quo_q;
   logic [OP_W-1:0] dvs_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;

   logic [OP_W:0]   shifted;
   logic [OP_W:0]   diff;

   assign shifted = {rem_q[OP_W-1:0], quo_q[OP_W-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         // negative trial difference means restore the shifted value
         if (!diff[OP_W]) begin
            rem_q <= diff;
            quo_q <= {quo_q[OP_W-2:0], 1'b1};
         end else begin
            rem_q <= shifted;
            quo_q <= {quo_q[OP_W-2:0], 1'b0};
         end
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CW'(OP_W - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q[OP_W-1:0];

endmodule

// File: rtl/instr_register_pipe.sv
// Pipelined instruction register: handshake FSM, one-cycle ALU stage,
// serial divider for DIV/MOD, DEPTH-entry result file, registered read.
module instr_register_pipe
   import instr_register_pkg::*;
#(
   parameter int OP_W  = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  opcode_t           opcode,
   input  logic [OP_W-1:0]   operand_a,
   input  logic [OP_W-1:0]   operand_b,
   input  logic [AW-1:0]     write_pointer,
   input  logic              rd_en,
   input  logic [AW-1:0]     read_pointer,
   output logic              rd_valid,
   output logic [3:0]        rd_opcode,
   output logic [OP_W-1:0]   rd_operand_a,
   output logic [OP_W-1:0]   rd_operand_b,
   output logic [2*OP_W-1:0] rd_result,
   output logic [3:0]        rd_flags
);

   typedef struct packed {
      logic [3:0]        op;
      logic [OP_W-1:0]   a;
      logic [OP_W-1:0]   b;
      logic [2*OP_W-1:0] res;
      logic [3:0]        flags;
   } entry_t;

   typedef enum logic {IDLE, DIVS} state_t;

   state_t state_q, state_nx;

   logic              accept;
   logic              div_start;
   logic              div_done;
   logic [OP_W-1:0]   div_quo;
   logic [OP_W-1:0]   div_rem;

   logic [2*OP_W-1:0] a2, b2;
   logic [2*OP_W-1:0] alu_res;
   logic [3:0]        alu_flags;

   logic              st_valid;
   logic [AW-1:0]     st_ptr;
   entry_t            st_ent;

   logic [AW-1:0]     dv_ptr;
   logic [3:0]        dv_op;
   logic [OP_W-1:0]   dv_a, dv_b;

   logic              wr_en;
   logic [AW-1:0]     wr_idx;
   entry_t            wr_ent;

   entry_t            mem [DEPTH];
   entry_t            rd_ent;

   assign wr_ready  = (state_q == IDLE);
   assign accept    = wr_valid && wr_ready;
   assign div_start = accept && is_div_op(opcode) && (operand_b != '0);

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE: if (div_start) state_nx = DIVS;
         DIVS: if (div_done)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign a2 = {{OP_W{1'b0}}, operand_a};
   assign b2 = {{OP_W{1'b0}}, operand_b};

   // DIV/MOD only reach this stage with a zero divisor
   always_comb begin
      alu_res   = '0;
      alu_flags = 4'b0000;
      alu_flags[FLAG_WRITTEN] = 1'b1;
      case (opcode)
         ZERO:  alu_res = '0;
         PASSA: alu_res = a2;
         PASSB: alu_res = b2;
         ADD: begin
            alu_res = a2 + b2;
            alu_flags[FLAG_CARRY] = alu_res[OP_W];
         end
         SUB: begin
            alu_res = {{OP_W{1'b0}}, operand_a - operand_b};
            alu_flags[FLAG_CARRY] = (operand_a < operand_b);
         end
         MULT:    alu_res = a2 * b2;
         DIV,
         MOD:     alu_flags[FLAG_DIV0] = 1'b1;
         default: alu_flags[FLAG_ILLEGAL] = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         st_valid <= 1'b0;
         st_ptr   <= '0;
         st_ent   <= '0;
         dv_ptr   <= '0;
         dv_op    <= '0;
         dv_a     <= '0;
         dv_b     <= '0;
      end else begin
         state_q  <= state_nx;
         st_valid <= accept && !div_start;
         if (accept && !div_start) begin
            st_ptr <= write_pointer;
            st_ent <= '{opcode, operand_a, operand_b, alu_res, alu_flags};
         end
         if (div_start) begin
            dv_ptr <= write_pointer;
            dv_op  <= opcode;
            dv_a   <= operand_a;
            dv_b   <= operand_b;
         end
      end
   end

   instr_divider_serial #(.OP_W(OP_W)) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (div_start),
      .dividend  (operand_a),
      .divisor   (operand_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = st_ptr;
      wr_ent = st_ent;
      if (st_valid) begin
         wr_en = 1'b1;
      end else if (div_done) begin
         wr_en  = 1'b1;
         wr_idx = dv_ptr;
         wr_ent = '{dv_op, dv_a, dv_b,
                    {{OP_W{1'b0}}, (dv_op == 4'(MOD)) ? div_rem : div_quo},
                    4'b1000};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
         mem[wr_idx] <= wr_ent;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_ent   <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (32'(read_pointer) < 32'(DEPTH)) rd_ent <= mem[read_pointer];
            else                                rd_ent <= '0;
         end
      end
   end

   assign rd_opcode    = rd_ent.op;
   assign rd_operand_a = rd_ent.a;
   assign rd_operand_b = rd_ent.b;
   assign rd_result    = rd_ent.res;
   assign rd_flags     = rd_ent.flags;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Scoreboard bench for instr_register_pipe: reads push expected entries,
// a negedge monitor pops and compares whenever rd_valid is high.
module tb_instr_register_pipe;
   import instr_register_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_valid;
   logic        wr_ready;
   opcode_t     opcode;
   logic [31:0] operand_a, operand_b;
   logic [4:0]  write_pointer;
   logic        rd_en;
   logic [4:0]  read_pointer;
   logic        rd_valid;
   logic [3:0]  rd_opcode;
   logic [31:0] rd_operand_a, rd_operand_b;
   logic [63:0] rd_result;
   logic [3:0]  rd_flags;

   typedef struct {
      int          id;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      logic [3:0]  fl;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rd_id = 0;

   instr_register_pipe #(.OP_W(32), .DEPTH(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .opcode        (opcode),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .write_pointer (write_pointer),
      .rd_en         (rd_en),
      .read_pointer  (read_pointer),
      .rd_valid      (rd_valid),
      .rd_opcode     (rd_opcode),
      .rd_operand_a  (rd_operand_a),
      .rd_operand_b  (rd_operand_b),
      .rd_result     (rd_result),
      .rd_flags      (rd_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (rd_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rd_valid: rd_valid=1 with empty scoreboard");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_flags} !==
                {e.op, e.a, e.b, e.res, e.fl}) begin
               n_bad++;
               $display("FAIL read%0d: got op=%h a=%h b=%h res=%h fl=%b, want op=%h a=%h b=%h res=%h fl=%b",
                        e.id, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_flags,
                        e.op, e.a, e.b, e.res, e.fl);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic wr(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] p);
      int w;
      w = 0;
      while (!wr_ready && w < 100) begin
         tick(1);
         w++;
      end
      if (!wr_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wr_wait: wr_ready stuck at 0, want 1");
      end
      wr_valid      = 1'b1;
      opcode        = opcode_t'(op);
      operand_a     = a;
      operand_b     = b;
      write_pointer = p;
      tick(1);
      wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [4:0] p, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] res, input logic [3:0] fl);
      exp_t e;
      e.id  = rd_id;
      e.op  = op;
      e.a   = a;
      e.b   = b;
      e.res = res;
      e.fl  = fl;
      exp_q.push_back(e);
      rd_id++;
      rd_en        = 1'b1;
      read_pointer = p;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic stall_len(input string name, input int want);
      int c;
      c = 0;
      while (!wr_ready && c < 100) begin
         tick(1);
         c++;
      end
      chk(name, 64'(c), 64'(want));
   endtask

   initial begin
      reset_n       = 1'b0;
      wr_valid      = 1'b0;
      opcode        = ZERO;
      operand_a     = '0;
      operand_b     = '0;
      write_pointer = '0;
      rd_en         = 1'b0;
      read_pointer  = '0;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      chk("reset_wr_ready", 64'(wr_ready), 64'd1);
      chk("reset_rd_valid", 64'(rd_valid), 64'd0);
      rd(5'd0,  4'h0, 32'h0, 32'h0, 64'h0, 4'b0000);
      rd(5'd31, 4'h0, 32'h0, 32'h0, 64'h0, 4'b0000);

      wr(4'h3, 32'hFFFF_FFFF, 32'h1, 5'd3);
      wr(4'h4, 32'd5, 32'd7, 5'd4);
      tick(1);
      rd(5'd3, 4'h3, 32'hFFFF_FFFF, 32'h1, 64'h1_0000_0000, 4'b1010);
      rd(5'd4, 4'h4, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE, 4'b1010);

      wr(4'h5, 32'hFFFF_FFFF, 32'h2, 5'd10);
      wr(4'h2, 32'h0, 32'h55, 5'd11);
      rd(5'd10, 4'h5, 32'hFFFF_FFFF, 32'h2, 64'h1_FFFF_FFFE, 4'b1000);
      rd(5'd11, 4'h2, 32'h0, 32'h55, 64'h55, 4'b1000);

      wr(4'h1, 32'h1234, 32'h0, 5'd12);
      rd(5'd12, 4'h0, 32'h0, 32'h0, 64'h0, 4'b0000);
      rd(5'd12, 4'h1, 32'h1234, 32'h0, 64'h1234, 4'b1000);

      wr(4'h6, 32'd100, 32'd7, 5'd5);
      stall_len("div_stall", 33);
      wr(4'h7, 32'd100, 32'd7, 5'd6);
      stall_len("mod_stall", 33);
      tick(1);
      rd(5'd5, 4'h6, 32'd100, 32'd7, 64'd14, 4'b1000);
      rd(5'd6, 4'h7, 32'd100, 32'd7, 64'd2, 4'b1000);

      wr(4'h6, 32'd9, 32'd0, 5'd8);
      chk("div0_no_stall", 64'(wr_ready), 64'd1);
      wr(4'hC, 32'd1, 32'd2, 5'd9);
      chk("illegal_no_stall", 64'(wr_ready), 64'd1);
      tick(1);
      rd(5'd8, 4'h6, 32'd9, 32'd0, 64'h0, 4'b1001);
      rd(5'd9, 4'hC, 32'd1, 32'd2, 64'h0, 4'b1100);
      tick(2);

      wr(4'h6, 32'd100, 32'd7, 5'd7);
      chk("div_busy", 64'(wr_ready), 64'd0);
      tick(9);
      reset_n = 1'b0;
      #1;
      chk("ready_in_reset", 64'(wr_ready), 64'd1);
      chk("rd_result_in_reset", rd_result, 64'h0);
      tick(2);
      reset_n = 1'b1;
      tick(1);
      chk("ready_after_reset", 64'(wr_ready), 64'd1);
      tick(40);
      rd(5'd7, 4'h0, 32'h0, 32'h0, 64'h0, 4'b0000);
      rd(5'd3, 4'h0, 32'h0, 32'h0, 64'h0, 4'b0000);

      tick(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
